// File: rtl/spi_tx_responder.sv
// SPI mode-0 peripheral transmitter: drives CIPO from a one-entry holding register
// and an 8-bit shift register, with SCLK/CS oversampled in the clk domain.
module spi_tx_responder #(
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       spi_cs_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       CIPO,
    output logic       cipo_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_underrun,
    output logic       tx_abort
);

    // DISARMED must ignore the reset values still flushing out of the synchronizers
    localparam int unsigned SETTLE_CYCLES = SYNC_STAGES + 2;
    localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_DISARMED,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_s, cs_s;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sclk_rise_q, sclk_rise_d;
    logic                   sclk_fall_q, sclk_fall_d;
    logic                   cs_rise_q, cs_rise_d;
    logic                   cs_fall_q, cs_fall_d;

    state_t                 state_q, state_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   done_q, done_d;
    logic                   underrun_q, underrun_d;
    logic                   abort_q, abort_d;
    logic                   load_evt;
    logic                   wr_accept;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sclk_sync_d[gi] = SCLK;
                assign cs_sync_d[gi]   = spi_cs_n;
            end else begin : g_rest
                assign sclk_sync_d[gi] = sclk_sync_q[gi-1];
                assign cs_sync_d[gi]   = cs_sync_q[gi-1];
            end
        end
    endgenerate

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    always_comb begin
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise_d = sclk_s & ~sclk_prev_q;
        sclk_fall_d = ~sclk_s & sclk_prev_q;
        cs_rise_d   = cs_s & ~cs_prev_q;
        cs_fall_d   = ~cs_s & cs_prev_q;
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load_evt    = 1'b0;
        wr_accept   = tx_valid && !hold_full_q;

        if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + 1'b1;
        end

        case (state_q)
            ST_DISARMED: begin
                if (settle_q == SETTLE_MAX && cs_s && cs_prev_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall_q) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = 3'd0;
                    load_evt  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // CS release wins over any SCLK edge landing in the same cycle
                if (cs_rise_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    abort_d   = (bit_cnt_q != 3'd0);
                end else if (sclk_rise_q) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    done_d    = (bit_cnt_q == 3'd7);
                end else if (sclk_fall_q) begin
                    if (bit_cnt_q == 3'd0) begin
                        load_evt = 1'b1;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = ST_DISARMED;
            end
        endcase

        if (load_evt) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (tx_valid) begin
                shift_d = tx_data;
            end else begin
                shift_d    = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end else if (wr_accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            state_q     <= ST_DISARMED;
            settle_q    <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            state_q     <= state_d;
            settle_q    <= settle_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign tx_ready    = !hold_full_q;
    assign busy        = (state_q == ST_ACTIVE);
    assign cipo_oe     = (state_q == ST_ACTIVE);
    assign CIPO        = (state_q == ST_ACTIVE) & shift_q[7];
    assign tx_done     = done_q;
    assign tx_underrun = underrun_q;
    assign tx_abort    = abort_q;

endmodule

// File: tb/tb_spi_tx_responder.sv
// Drives the responder as an SPI mode-0 controller and compares sampled CIPO bytes
// and status pulses with a queue-based model of the holding register.
module tb_spi_tx_responder;

    localparam int         HALF = 6;
    localparam logic [7:0] IDLE = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       SCLK;
    logic       spi_cs_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       CIPO;
    logic       cipo_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_underrun;
    logic       tx_abort;

    spi_tx_responder #(
        .IDLE_BYTE  (8'hFF),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SCLK       (SCLK),
        .spi_cs_n   (spi_cs_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .CIPO       (CIPO),
        .cipo_oe    (cipo_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_underrun(tx_underrun),
        .tx_abort   (tx_abort)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_done  = 0;
    int n_under = 0;
    int n_abort = 0;
    int n_act   = 0;
    int last_under_cyc = 0;
    int cs_cyc  = 0;

    logic [7:0] model_q[$];
    logic [7:0] wdat[4];
    bit         wen[4];
    logic [7:0] rdat[4];
    logic [7:0] expd[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_abort) n_abort++;
        if (tx_underrun) begin
            n_under++;
            last_under_cyc = cyc;
        end
        if (busy || cipo_oe) n_act++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic write_byte(input logic [7:0] d);
        check("tx_ready_before_write", 32'(tx_ready), 32'(model_q.size() == 0));
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        if (model_q.size() == 0) model_q.push_back(d);
    endtask

    // One CS-low transaction of nbytes; abort_bits != 0 releases CS after that many bits of byte 0.
    task automatic do_xfer(input int nbytes, input int abort_bits, input bit bypass,
                           input logic [7:0] bypass_dat);
        int d0, u0, a0, exp_under, ncomp;
        bit stop;
        d0 = n_done; u0 = n_under; a0 = n_abort;
        exp_under = 0;
        stop = 1'b0;
        for (int b = 0; b < 4; b++) rdat[b] = 8'h00;
        if (wen[0] && !bypass) write_byte(wdat[0]);
        spi_cs_n = 1'b0;
        cs_cyc = cyc;
        if (bypass) begin
            tick(3);
            tx_data  = bypass_dat;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            check("bypass_tx_ready", 32'(tx_ready), 32'd1);
            tick(2);
        end else begin
            tick(HALF);
        end
        for (int b = 0; b < nbytes && !stop; b++) begin
            if (bypass && b == 0) begin
                expd[b] = bypass_dat;
            end else if (model_q.size() != 0) begin
                expd[b] = model_q.pop_front();
            end else begin
                expd[b] = IDLE;
                exp_under++;
            end
            for (int k = 0; k < 8; k++) begin
                if (abort_bits != 0 && k == abort_bits) begin
                    stop = 1'b1;
                    break;
                end
                SCLK = 1'b1;
                rdat[b][7-k] = CIPO;
                if (k == 1 && b + 1 < nbytes && wen[b+1]) begin
                    write_byte(wdat[b+1]);
                    tick(HALF - 1);
                end else begin
                    tick(HALF);
                end
                if (b == nbytes - 1 && k == 7) spi_cs_n = 1'b1;
                SCLK = 1'b0;
                tick(HALF);
            end
        end
        if (stop) spi_cs_n = 1'b1;
        tick(8);
        ncomp = stop ? 0 : nbytes;
        for (int b = 0; b < ncomp; b++) check("cipo_byte", 32'(rdat[b]), 32'(expd[b]));
        check("tx_done_count", 32'(n_done - d0), 32'(ncomp));
        check("tx_underrun_count", 32'(n_under - u0), 32'(exp_under));
        check("tx_abort_count", 32'(n_abort - a0), 32'(stop));
        check("busy_after", 32'(busy), 32'd0);
        check("tx_ready_after", 32'(tx_ready), 32'(model_q.size() == 0));
        $display("xfer bytes=%0d abort_bits=%0d bypass=%0d byte0 got=%02h exp=%02h underruns=%0d",
                 nbytes, abort_bits, bypass, rdat[0], expd[0], exp_under);
    endtask

    initial begin
        int act0;
        logic [7:0] rb;
        rst = 1'b1; SCLK = 1'b0; spi_cs_n = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        for (int b = 0; b < 4; b++) begin wen[b] = 1'b0; wdat[b] = 8'h00; end
        tick(3);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_cipo", 32'(CIPO), 32'd0);
        check("reset_cipo_oe", 32'(cipo_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pulses", {29'd0, tx_done, tx_underrun, tx_abort}, 32'd0);
        rst = 1'b0;
        tick(8);

        // single byte
        wen[0] = 1'b1; wdat[0] = 8'h3C;
        do_xfer(1, 0, 1'b0, 8'h00);

        // underrun, pulse 4 cycles after CS fall
        wen[0] = 1'b0;
        do_xfer(1, 0, 1'b0, 8'h00);
        check("underrun_latency", 32'(last_under_cyc - cs_cyc), 32'd4);

        // back-to-back
        wen[0] = 1'b1; wdat[0] = 8'hA5; wen[1] = 1'b1; wdat[1] = 8'h5A;
        do_xfer(2, 0, 1'b0, 8'h00);

        // abort after 3 bits, holding keeps 0x11 for the next transfer
        wen[0] = 1'b1; wdat[0] = 8'hC3; wen[1] = 1'b1; wdat[1] = 8'h11;
        do_xfer(2, 3, 1'b0, 8'h00);
        wen[0] = 1'b0; wen[1] = 1'b0;
        do_xfer(1, 0, 1'b0, 8'h00);

        // bypass on the CS-fall load
        do_xfer(1, 0, 1'b1, 8'h77);

        // reset while CS low mid-byte
        rb = 8'($urandom);
        write_byte(rb);
        spi_cs_n = 1'b0;
        tick(HALF);
        for (int k = 0; k < 3; k++) begin
            SCLK = 1'b1; tick(HALF);
            SCLK = 1'b0; tick(HALF);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_q.delete();
        act0 = n_act;
        tick(20);
        check("reset_mid_no_drive_cs_low", 32'(n_act - act0), 32'd0);
        spi_cs_n = 1'b1;
        tick(8);
        check("reset_mid_no_drive_cs_high", 32'(n_act - act0), 32'd0);
        check("reset_mid_tx_ready", 32'(tx_ready), 32'd1);
        wen[0] = 1'b1; wdat[0] = 8'($urandom);
        do_xfer(1, 0, 1'b0, 8'h00);

        // randomized transfers
        for (int t = 0; t < 6; t++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < 4; b++) begin
                wen[b]  = 1'($urandom_range(0, 1));
                wdat[b] = 8'($urandom);
            end
            if (model_q.size() != 0) wen[0] = 1'b0;
            do_xfer(nb, 0, 1'b0, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
